// File: rtl/paddle_ctrl.sv
// paddle_ctrl: raw up/down buttons -> bounded 10-bit paddle Y position.
// Two-flop synchronisers and per-button debouncers feed a 3-state FSM.
// A free-running divider sets the move rate.
// Optional build macro PADDLE_ACCEL_EN doubles the step after 16 held ticks.
module paddle_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_DIV        = 100000,
  parameter int STEP            = 1,
  parameter int POS_TOP         = 71,
  parameter int POS_BOT         = 371,
  parameter int POS_START       = 221
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] pos,
  output logic       up_db,
  output logic       down_db,
  output logic       at_top,
  output logic       at_bot
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [9:0]       P_TOP    = 10'(POS_TOP);
  localparam logic [9:0]       P_BOT    = 10'(POS_BOT);
  localparam logic [9:0]       P_START  = 10'(POS_START);
  localparam logic [9:0]       STEP1    = 10'(STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic            up_s1_q, up_s1_d, up_s2_q, up_s2_d;
  logic            dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d;
  logic [DB_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic            up_db_q, up_db_d, dn_db_q, dn_db_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic            tick;
  logic [1:0]      state_q, state_d;
  logic [9:0]      pos_q, pos_d;
  logic [9:0]      step;

  // Synchroniser next-state: two flops per button
  always_comb begin
    up_s1_d = btn_up;
    up_s2_d = up_s1_q;
    dn_s1_d = btn_down;
    dn_s2_d = dn_s1_q;
  end

  // Debouncers: accept a new level only after it holds DEBOUNCE_CYCLES cycles
  always_comb begin
    up_cnt_d = '0;
    up_db_d  = up_db_q;
    if (up_s2_q != up_db_q) begin
      if (up_cnt_q == DB_LAST) up_db_d  = up_s2_q;
      else                     up_cnt_d = up_cnt_q + 1'b1;
    end
    dn_cnt_d = '0;
    dn_db_d  = dn_db_q;
    if (dn_s2_q != dn_db_q) begin
      if (dn_cnt_q == DB_LAST) dn_db_d  = dn_s2_q;
      else                     dn_cnt_d = dn_cnt_q + 1'b1;
    end
  end

  // Free-running move divider; tick marks its last count
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Direction FSM; always passes through IDLE between UP and DOWN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (up_db_q && !dn_db_q)      state_d = S_UP;
        else if (dn_db_q && !up_db_q) state_d = S_DOWN;
      end
      S_UP:    if (!up_db_q || dn_db_q) state_d = S_IDLE;
      S_DOWN:  if (!dn_db_q || up_db_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PADDLE_ACCEL_EN
  localparam logic [9:0] STEP2 = 10'(2 * STEP);
  logic [4:0] hold_cnt_q, hold_cnt_d;

  // Held-tick counter: saturates at 31, cleared while idle
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == S_IDLE)
      hold_cnt_d = '0;
    else if (tick && (hold_cnt_q != 5'd31))
      hold_cnt_d = hold_cnt_q + 5'd1;
    step = hold_cnt_q[4] ? STEP2 : STEP1;
  end

  // Held-tick counter register
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) hold_cnt_q <= '0;
    else      hold_cnt_q <= hold_cnt_d;
  end
`else
  // Constant step when acceleration is not built in
  always_comb begin
    step = STEP1;
  end
`endif

  // Position update on tick using the registered direction, clamped to limits
  always_comb begin
    pos_d = pos_q;
    if (tick) begin
      case (state_q)
        S_UP:    pos_d = ((pos_q - P_TOP) < step) ? P_TOP : pos_q - step;
        S_DOWN:  pos_d = ((P_BOT - pos_q) < step) ? P_BOT : pos_q + step;
        default: pos_d = pos_q;
      endcase
    end
  end

  // All state registers, asynchronously reset
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      up_s1_q  <= 1'b0;
      up_s2_q  <= 1'b0;
      dn_s1_q  <= 1'b0;
      dn_s2_q  <= 1'b0;
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      up_db_q  <= 1'b0;
      dn_db_q  <= 1'b0;
      div_q    <= '0;
      state_q  <= S_IDLE;
      pos_q    <= P_START;
    end else begin
      up_s1_q  <= up_s1_d;
      up_s2_q  <= up_s2_d;
      dn_s1_q  <= dn_s1_d;
      dn_s2_q  <= dn_s2_d;
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
      up_db_q  <= up_db_d;
      dn_db_q  <= dn_db_d;
      div_q    <= div_d;
      state_q  <= state_d;
      pos_q    <= pos_d;
    end
  end

  // Outputs
  always_comb begin
    pos     = pos_q;
    up_db   = up_db_q;
    down_db = dn_db_q;
    at_top  = (pos_q == P_TOP);
    at_bot  = (pos_q == P_BOT);
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed, table-driven bench for paddle_ctrl with small
// debounce/divider parameters. Honours PADDLE_ACCEL_EN for the accel check.
module tb_paddle_ctrl;

  logic       dclk;
  logic       clr;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] pos;
  logic       up_db;
  logic       down_db;
  logic       at_top;
  logic       at_bot;

  int n_tests = 0;
  int n_fail  = 0;
  logic range_bad = 1'b0;

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MOVE_DIV(8),
    .STEP(1),
    .POS_TOP(71),
    .POS_BOT(371),
    .POS_START(221)
  ) dut (
    .dclk(dclk),
    .clr(clr),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .pos(pos),
    .up_db(up_db),
    .down_db(down_db),
    .at_top(at_top),
    .at_bot(at_bot)
  );

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  // pos must stay inside the playfield whenever out of reset
  always @(negedge dclk) begin
    if (clr === 1'b1 && (pos < 10'd71 || pos > 10'd371)) range_bad = 1'b1;
  end

  typedef struct {
    logic        up;
    logic        dn;
    int unsigned cyc;
    logic [9:0]  pos;
    logic        udb;
    logic        ddb;
    logic        top;
    logic        bot;
    string       name;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(posedge dclk);
    @(negedge dclk);
  endtask

  task automatic chk_all(input string nm, input logic [9:0] p, input logic u,
                         input logic d, input logic t, input logic b);
    chk({nm, ".pos"}, pos, p);
    chk({nm, ".up_db"}, {9'd0, up_db}, {9'd0, u});
    chk({nm, ".down_db"}, {9'd0, down_db}, {9'd0, d});
    chk({nm, ".at_top"}, {9'd0, at_top}, {9'd0, t});
    chk({nm, ".at_bot"}, {9'd0, at_bot}, {9'd0, b});
  endtask

  initial begin
    logic [9:0] e_a16;
    logic [9:0] e_a17;
    logic [9:0] e_rep;
`ifdef PADDLE_ACCEL_EN
    e_a16 = 10'd237; e_a17 = 10'd239; e_rep = 10'd241;
`else
    e_a16 = 10'd237; e_a17 = 10'd238; e_rep = 10'd240;
`endif
    // Cycle counts are relative to reset release; ticks fall every 8th edge.
    vecs[0]  = '{1'b0, 1'b0, 8,    10'd221, 1'b0, 1'b0, 1'b0, 1'b0, "idle"};
    vecs[1]  = '{1'b1, 1'b0, 3,    10'd221, 1'b0, 1'b0, 1'b0, 1'b0, "glitch"};
    vecs[2]  = '{1'b0, 1'b0, 5,    10'd221, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_gone"};
    vecs[3]  = '{1'b1, 1'b0, 5,    10'd221, 1'b0, 1'b0, 1'b0, 1'b0, "press_5cyc"};
    vecs[4]  = '{1'b1, 1'b0, 1,    10'd221, 1'b1, 1'b0, 1'b0, 1'b0, "press_6cyc"};
    vecs[5]  = '{1'b1, 1'b0, 2,    10'd220, 1'b1, 1'b0, 1'b0, 1'b0, "first_move"};
    vecs[6]  = '{1'b1, 1'b0, 72,   10'd211, 1'b1, 1'b0, 1'b0, 1'b0, "ten_ticks"};
    vecs[7]  = '{1'b0, 1'b0, 8,    10'd211, 1'b0, 1'b0, 1'b0, 1'b0, "up_release"};
    vecs[8]  = '{1'b1, 1'b1, 168,  10'd211, 1'b1, 1'b1, 1'b0, 1'b0, "both_hold"};
    vecs[9]  = '{1'b0, 1'b1, 16,   10'd213, 1'b0, 1'b1, 1'b0, 1'b0, "drop_up"};
    vecs[10] = '{1'b0, 1'b0, 16,   10'd213, 1'b0, 1'b0, 1'b0, 1'b0, "release_all"};
    vecs[11] = '{1'b1, 1'b0, 1128, 10'd72,  1'b1, 1'b0, 1'b0, 1'b0, "up_to_72"};
    vecs[12] = '{1'b1, 1'b0, 40,   10'd71,  1'b1, 1'b0, 1'b1, 1'b0, "top_clamp"};
    vecs[13] = '{1'b0, 1'b0, 8,    10'd71,  1'b0, 1'b0, 1'b1, 1'b0, "top_release"};
    vecs[14] = '{1'b0, 1'b1, 8,    10'd72,  1'b0, 1'b1, 1'b0, 1'b0, "down_first"};
    vecs[15] = '{1'b0, 1'b1, 2392, 10'd371, 1'b0, 1'b1, 1'b0, 1'b1, "down_to_bot"};
    vecs[16] = '{1'b0, 1'b1, 40,   10'd371, 1'b0, 1'b1, 1'b0, 1'b1, "bot_clamp"};
    vecs[17] = '{1'b0, 1'b0, 16,   10'd371, 1'b0, 1'b0, 1'b0, 1'b1, "bot_release"};

    clr = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    @(negedge dclk);
    @(negedge dclk);
    chk_all("reset", 10'd221, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;

    foreach (vecs[i]) begin
      btn_up   = vecs[i].up;
      btn_down = vecs[i].dn;
      run(vecs[i].cyc);
      chk_all(vecs[i].name, vecs[i].pos, vecs[i].udb, vecs[i].ddb, vecs[i].top, vecs[i].bot);
    end

    // Reset mid-movement, asserted between clock edges
    btn_up = 1'b1;
    run(40);
    #2;
    clr = 1'b0; btn_up = 1'b0;
    #1;
    chk_all("async_reset", 10'd221, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge dclk);
    clr = 1'b1;
    run(32);
    chk_all("post_reset_hold", 10'd221, 1'b0, 1'b0, 1'b0, 1'b0);

    // Long hold down from the start position, release, re-press
    btn_down = 1'b1;
    run(128);
    chk("hold16.pos", pos, e_a16);
    run(8);
    chk("hold17.pos", pos, e_a17);
    btn_down = 1'b0;
    run(16);
    chk("hold_release.pos", pos, e_a17);
    btn_down = 1'b1;
    run(16);
    chk("repress.pos", pos, e_rep);
    btn_down = 1'b0;
    run(16);

    chk("pos_range", {9'd0, range_bad}, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
